// File: rtl/fifo_cmd_pkg.sv
// Shared definitions for the host-to-core command receiver: opcodes,
// header field positions, FSM state encoding and a saturating counter helper.
package fifo_cmd_pkg;

  // Header opcodes (header bits [31:28])
  localparam logic [3:0] OP_WRITE       = 4'd1;
  localparam logic [3:0] OP_WRITE_START = 4'd2;
  localparam logic [3:0] OP_START       = 4'd3;

  // Header field bit positions
  localparam int HDR_OP_MSB   = 31;
  localparam int HDR_OP_LSB   = 28;
  localparam int HDR_CNT_MSB  = 15;
  localparam int HDR_CNT_LSB  = 8;
  localparam int HDR_ADDR_MSB = 7;
  localparam int HDR_ADDR_LSB = 0;

  // FSM state encoding
  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] S_IDLE         = 4'd0;
  localparam logic [STATE_W-1:0] S_HDR_WAIT     = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE       = 4'd2;
  localparam logic [STATE_W-1:0] S_DATA_REQ     = 4'd3;
  localparam logic [STATE_W-1:0] S_DATA_WAIT    = 4'd4;
  localparam logic [STATE_W-1:0] S_FINISH       = 4'd5;
  localparam logic [STATE_W-1:0] S_START        = 4'd6;
  localparam logic [STATE_W-1:0] S_WAIT_BUSY_HI = 4'd7;
  localparam logic [STATE_W-1:0] S_WAIT_BUSY_LO = 4'd8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE         = S_IDLE,
    ST_HDR_WAIT     = S_HDR_WAIT,
    ST_DECODE       = S_DECODE,
    ST_DATA_REQ     = S_DATA_REQ,
    ST_DATA_WAIT    = S_DATA_WAIT,
    ST_FINISH       = S_FINISH,
    ST_START        = S_START,
    ST_WAIT_BUSY_HI = S_WAIT_BUSY_HI,
    ST_WAIT_BUSY_LO = S_WAIT_BUSY_LO
  } state_t;

  // Increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fifo_cmd_receiver_reg_bank.sv
// Bank of NUM_REGS 32-bit user registers with one synchronous write port
// and a synchronous clear. Register i is exposed at regs[32*i +: 32].
module cmd_reg_bank
  import fifo_cmd_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int AW       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [31:0]             wdata,
  output logic [32*NUM_REGS-1:0]  regs
);

  // Clear on reset, otherwise write the addressed register when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == AW'(i)) regs[32*i +: 32] <= wdata;
      end
    end
  end

endmodule

// File: rtl/fifo_cmd_receiver.sv
// Host-to-core command receiver. Pops header-framed register-write packets
// from a standard-read-mode FIFO, writes them into the user register bank,
// and optionally runs a req/busy start handshake with the user core.
//
// FIFO handshake: rcv_en_32 is the FIFO rd_en. It is only raised while the
// FIFO reports non-empty, and the popped word is presented on rcv_data_32 in
// the following cycle, where the FSM (HDR_WAIT / DATA_WAIT) captures it.
// rcv_en_32 is decoded from the current state so the pop decision sees the
// live empty flag; the states that raise it always leave on the same edge,
// so it can never be high two cycles in a row.
module fifo_cmd_receiver
  import fifo_cmd_pkg::*;
#(
  parameter int NUM_REGS     = 4,
  parameter int BUSY_TIMEOUT = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_32,
  input  logic [31:0]             rcv_data_32,
  input  logic                    data_empty_32,
  output logic                    rcv_en_32,
  output logic [32*NUM_REGS-1:0]  user_regs,
  output logic                    req_out,
  input  logic                    busy_in,
  output logic                    cmd_done,
  output logic [7:0]              err_count,
  output logic [STATE_W-1:0]      state_dbg
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [8:0]    NREGS9   = 9'(NUM_REGS);

  state_t        state;
  logic [3:0]    op_q;
  logic [7:0]    cnt_q;
  logic [7:0]    base_q;
  logic [7:0]    k_q;
  logic [TW-1:0] tmo_q;
  logic [8:0]    addr9;
  logic          bank_we;

  // Target address is formed in 9 bits so A+k past 255 never aliases low regs
  assign addr9     = {1'b0, base_q} + {1'b0, k_q};
  assign bank_we   = (state == ST_DATA_WAIT) && (addr9 < NREGS9);
  assign rcv_en_32 = ((state == ST_IDLE) || (state == ST_DATA_REQ)) && !data_empty_32;
  assign state_dbg = state;

  cmd_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_bank (
    .clk   (clk),
    .rst   (rst_32),
    .we    (bank_we),
    .addr  (addr9[AW-1:0]),
    .wdata (rcv_data_32),
    .regs  (user_regs)
  );

  // Packet decode / handshake FSM with registered pulse and error outputs
  always_ff @(posedge clk) begin
    if (rst_32) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      k_q       <= '0;
      tmo_q     <= '0;
      req_out   <= 1'b0;
      cmd_done  <= 1'b0;
      err_count <= '0;
    end else begin
      req_out  <= 1'b0;
      cmd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!data_empty_32) state <= ST_HDR_WAIT;
        end
        ST_HDR_WAIT: begin
          op_q   <= rcv_data_32[HDR_OP_MSB:HDR_OP_LSB];
          cnt_q  <= rcv_data_32[HDR_CNT_MSB:HDR_CNT_LSB];
          base_q <= rcv_data_32[HDR_ADDR_MSB:HDR_ADDR_LSB];
          k_q    <= '0;
          state  <= ST_DECODE;
        end
        ST_DECODE: begin
          if (op_q == OP_START) begin
            state <= ST_START;
          end else if ((op_q == OP_WRITE || op_q == OP_WRITE_START) && cnt_q != 8'd0) begin
            state <= ST_DATA_REQ;
          end else begin
            err_count <= sat_inc8(err_count);
            state     <= ST_IDLE;
          end
        end
        ST_DATA_REQ: begin
          // Starvation just stalls here; the host may be slow
          if (!data_empty_32) state <= ST_DATA_WAIT;
        end
        ST_DATA_WAIT: begin
          k_q <= k_q + 8'd1;
          if (k_q + 8'd1 == cnt_q) state <= ST_FINISH;
          else                     state <= ST_DATA_REQ;
        end
        ST_FINISH: begin
          cmd_done <= 1'b1;
          state    <= (op_q == OP_WRITE_START) ? ST_START : ST_IDLE;
        end
        ST_START: begin
          req_out <= 1'b1;
          tmo_q   <= '0;
          state   <= ST_WAIT_BUSY_HI;
        end
        ST_WAIT_BUSY_HI: begin
          if (busy_in) begin
            tmo_q <= '0;
            state <= ST_WAIT_BUSY_LO;
          end else if (tmo_q == TMO_LAST) begin
            err_count <= sat_inc8(err_count);
            state     <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WAIT_BUSY_LO: begin
          if (!busy_in) begin
            state <= ST_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            err_count <= sat_inc8(err_count);
            state     <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_cmd_receiver.sv
// Bench for fifo_cmd_receiver: a behavioural standard-read FIFO, an
// auto-responding busy model, a table of packets with expected results,
// and hand-written sequences for latency, starvation, timeouts and reset.
module tb_fifo_cmd_receiver;
  import fifo_cmd_pkg::*;

  localparam int NUM_REGS = 4;
  localparam int TMO      = 20;
  localparam int W        = 32 * NUM_REGS;

  logic          clk = 1'b0;
  logic          rst_32 = 1'b1;
  logic [31:0]   rcv_data_32 = '0;
  logic          data_empty_32 = 1'b1;
  logic          rcv_en_32;
  logic [W-1:0]  user_regs;
  logic          req_out;
  logic          busy_in = 1'b0;
  logic          cmd_done;
  logic [7:0]    err_count;
  logic [3:0]    state_dbg;

  fifo_cmd_receiver #(
    .NUM_REGS     (NUM_REGS),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_32        (rst_32),
    .rcv_data_32   (rcv_data_32),
    .data_empty_32 (data_empty_32),
    .rcv_en_32     (rcv_en_32),
    .user_regs     (user_regs),
    .req_out       (req_out),
    .busy_in       (busy_in),
    .cmd_done      (cmd_done),
    .err_count     (err_count),
    .state_dbg     (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Bench state
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  logic last_en = 1'b0;
  int done_cnt = 0, req_cnt = 0, done_cyc = 0, req_cyc = 0;
  bit busy_auto = 1'b1;
  int busy_cnt = 0, busy_left = 0;

  typedef struct {
    string           name;
    logic [3:0][31:0] words;   // words[0] is the header
    int              n;
    logic [7:0]      exp_err;
    logic [W-1:0]    exp_regs; // {r3, r2, r1, r0}
    int              exp_done;
    int              exp_req;
  } vec_t;

  localparam int NV = 9;
  vec_t vec[NV];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    data_empty_32 = 1'b0;
  endtask

  // One clock: sample outputs mid-cycle, then advance the FIFO and busy models
  task automatic tick();
    logic en;
    logic [W-1:0] e;
    #1;
    en = rcv_en_32;
    if (en) begin
      check("rd_not_empty", W'(fifo_q.size() != 0), W'(1));
      check("rd_not_back_to_back", W'(last_en), W'(0));
    end
    last_en = en;
    if (cmd_done) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done got regs %h expected no cmd_done", user_regs);
      end else begin
        e = exp_q.pop_front();
        checks--;
        check("sb_regs_at_done", user_regs, e);
      end
    end
    if (req_out) begin
      req_cnt++;
      req_cyc = cyc;
      if (busy_auto) busy_cnt = 2;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (en && fifo_q.size() != 0) rcv_data_32 = fifo_q.pop_front();
    data_empty_32 = (fifo_q.size() == 0);
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        busy_in = 1'b1;
        busy_left = 10;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy_in = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(fifo_q.size() == 0 && state_dbg == ST_IDLE && !cmd_done && !busy_in &&
             busy_cnt == 0 && busy_left == 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s idle_timeout got state %0d expected %0d", name, state_dbg, ST_IDLE);
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string name);
    int n = 0;
    while (state_dbg != st && n < budget) begin
      tick();
      n++;
    end
    check(name, W'(state_dbg), W'(st));
  endtask

  task automatic set_vec(input int i, input string name, input int n,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input logic [7:0] err, input logic [W-1:0] regs,
                         input int done, input int req);
    vec[i].name = name;
    vec[i].words[0] = w0;
    vec[i].words[1] = w1;
    vec[i].words[2] = w2;
    vec[i].words[3] = w3;
    vec[i].n = n;
    vec[i].exp_err = err;
    vec[i].exp_regs = regs;
    vec[i].exp_done = done;
    vec[i].exp_req = req;
  endtask

  initial begin
    int n;
    // Packets applied in order; register state accumulates row to row
    set_vec(0, "write_a0_n2", 3, 32'h1000_0200, 32'hDEADBEEF, 32'h12345678, 32'h0, 8'd0,
            {32'h0, 32'h0, 32'h12345678, 32'hDEADBEEF}, 1, 0);
    set_vec(1, "write_start_a3", 2, 32'h2000_0103, 32'h5A5A5A5A, 32'h0, 32'h0, 8'd0,
            {32'h5A5A5A5A, 32'h0, 32'h12345678, 32'hDEADBEEF}, 1, 1);
    set_vec(2, "write_overrun_a3", 4, 32'h1000_0303, 32'h1, 32'h2, 32'h3, 8'd0,
            {32'h1, 32'h0, 32'h12345678, 32'hDEADBEEF}, 1, 0);
    set_vec(3, "bad_opcode", 1, 32'h7000_0000, 32'h0, 32'h0, 32'h0, 8'd1,
            {32'h1, 32'h0, 32'h12345678, 32'hDEADBEEF}, 0, 0);
    set_vec(4, "write_after_bad", 2, 32'h1000_0100, 32'hAA, 32'h0, 32'h0, 8'd1,
            {32'h1, 32'h0, 32'h12345678, 32'hAA}, 1, 0);
    set_vec(5, "write_n0", 1, 32'h1000_0002, 32'h0, 32'h0, 32'h0, 8'd2,
            {32'h1, 32'h0, 32'h12345678, 32'hAA}, 0, 0);
    set_vec(6, "start_only", 1, 32'h3000_0000, 32'h0, 32'h0, 32'h0, 8'd2,
            {32'h1, 32'h0, 32'h12345678, 32'hAA}, 0, 1);
    set_vec(7, "addr_no_wrap", 3, 32'h1000_02FF, 32'h77, 32'h88, 32'h0, 8'd2,
            {32'h1, 32'h0, 32'h12345678, 32'hAA}, 1, 0);
    set_vec(8, "write_a2_n2", 3, 32'h1000_0202, 32'hCAFEF00D, 32'h0BADC0DE, 32'h0, 8'd2,
            {32'h0BADC0DE, 32'hCAFEF00D, 32'h12345678, 32'hAA}, 1, 0);

    // Reset
    repeat (3) tick();
    check("rst_regs", user_regs, '0);
    check("rst_err", W'(err_count), W'(0));
    check("rst_state", W'(state_dbg), W'(ST_IDLE));
    check("rst_outs", W'({rcv_en_32, req_out, cmd_done}), W'(0));
    rst_32 = 1'b0;
    tick();

    // Table-driven packets
    for (int r = 0; r < NV; r++) begin
      done_cnt = 0;
      req_cnt = 0;
      for (int i = 0; i < vec[r].n; i++) push(vec[r].words[i]);
      if (vec[r].exp_done != 0) exp_q.push_back(vec[r].exp_regs);
      wait_idle(200, vec[r].name);
      check({vec[r].name, "_regs"}, user_regs, vec[r].exp_regs);
      check({vec[r].name, "_err"}, W'(err_count), W'(vec[r].exp_err));
      check({vec[r].name, "_done_cnt"}, W'(done_cnt), W'(vec[r].exp_done));
      check({vec[r].name, "_req_cnt"}, W'(req_cnt), W'(vec[r].exp_req));
      if (vec[r].exp_done != 0 && vec[r].exp_req != 0)
        check({vec[r].name, "_req_after_done"}, W'(req_cyc > done_cyc), W'(1));
    end

    // Header-to-first-write latency: visible exactly 5 cycles after the pop starts
    push(32'h1000_0100);
    push(32'h5555);
    exp_q.push_back({32'h0BADC0DE, 32'hCAFEF00D, 32'h12345678, 32'h5555});
    repeat (4) tick();
    check("latency_not_yet", W'(user_regs[31:0]), W'(32'hAA));
    tick();
    check("latency_at_5", W'(user_regs[31:0]), W'(32'h5555));
    wait_idle(50, "latency_pkt");

    // FIFO starvation mid-packet: stall in DATA_REQ with no reads
    push(32'h1000_0200);
    repeat (3) tick();
    check("starve_state", W'(state_dbg), W'(ST_DATA_REQ));
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_en || state_dbg != ST_DATA_REQ) n++;
    end
    check("starve_no_reads", W'(n), W'(0));
    push(32'h11);
    push(32'h22);
    exp_q.push_back({32'h0BADC0DE, 32'hCAFEF00D, 32'h22, 32'h11});
    wait_idle(50, "starve_pkt");
    check("starve_regs", user_regs, {32'h0BADC0DE, 32'hCAFEF00D, 32'h22, 32'h11});
    check("starve_err", W'(err_count), W'(2));

    // Busy never rises: timeout out of WAIT_BUSY_HI
    busy_auto = 1'b0;
    req_cnt = 0;
    push(32'h3000_0000);
    wait_idle(100, "tmo_hi");
    check("tmo_hi_err", W'(err_count), W'(3));
    check("tmo_hi_req", W'(req_cnt), W'(1));

    // Busy never falls: timeout out of WAIT_BUSY_LO
    push(32'h3000_0000);
    wait_state(ST_WAIT_BUSY_HI, 20, "tmo_lo_reach_hi");
    busy_in = 1'b1;
    tick();
    wait_state(ST_IDLE, 100, "tmo_lo_return");
    check("tmo_lo_err", W'(err_count), W'(4));
    busy_in = 1'b0;
    busy_auto = 1'b1;
    tick();

    // Reset mid-packet after the first data word
    push(32'h1000_0300);
    push(32'h99);
    n = 0;
    while (user_regs[31:0] != 32'h99 && n < 20) begin
      tick();
      n++;
    end
    check("mid_first_word", W'(user_regs[31:0]), W'(32'h99));
    rst_32 = 1'b1;
    repeat (2) tick();
    rst_32 = 1'b0;
    check("mid_rst_regs", user_regs, '0);
    check("mid_rst_err", W'(err_count), W'(0));
    check("mid_rst_state", W'(state_dbg), W'(ST_IDLE));
    push(32'h1000_0101);
    push(32'hBEEF);
    exp_q.push_back({32'h0, 32'h0, 32'hBEEF, 32'h0});
    wait_idle(50, "post_rst_pkt");
    check("post_rst_regs", user_regs, {32'h0, 32'h0, 32'hBEEF, 32'h0});

    // err_count saturation
    for (int i = 0; i < 260; i++) push(32'h0000_0000);
    wait_idle(2000, "sat");
    check("err_saturate", W'(err_count), W'(8'hFF));

    check("sb_drained", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_cmd_receiver.md
Name: fifo_cmd_receiver

Overview:
Host-to-core command path. Pops 32-bit words from the host input FIFO (fifo_32x512, standard read mode) and decodes header-framed register-write packets into a bank of user registers. Optionally pulses a start request to the user core and waits for its busy handshake. Sits between input_fifo_32 and the user core, mirroring the core-to-host send path.

Parameters:
NUM_REGS, 4, number of 32-bit user registers (1..16)
BUSY_TIMEOUT, 1000000, max cycles in WAIT_BUSY before forced return to IDLE

Ports:
clk  input  1  system clock (bus_clk)
rst_32  input  1  synchronous, active-high reset
rcv_data_32  input  32  input FIFO dout; valid the cycle after rcv_en_32
data_empty_32  input  1  input FIFO empty
rcv_en_32  output  1  input FIFO rd_en
user_regs  output  32*NUM_REGS  register bank; reg i at bits [32*i+31:32*i]
req_out  output  1  one-cycle start pulse to user core
busy_in  input  1  user core busy
cmd_done  output  1  one-cycle pulse when a packet is fully applied
err_count  output  8  saturating count of rejected headers/timeouts

Behaviour:
- Reset: all user_regs=0, req_out=0, rcv_en_32=0, cmd_done=0, err_count=0, state=IDLE. Reset mid-packet abandons the packet; any partially written registers are cleared by the reset.
- Header word: [31:28] opcode (1=WRITE, 2=WRITE_START, 3=START_ONLY); [15:8] count N; [7:0] start address A.
- Read rule: rcv_en_32 asserts only when data_empty_32=0, for one cycle per word. The word is captured on the following cycle. rcv_en_32 is never asserted in two consecutive cycles.
- States:
  - IDLE: if !empty, assert rcv_en_32 and go to HDR_WAIT.
  - HDR_WAIT: latch the header and go to DECODE.
  - DECODE:
    - Opcode 3 goes to START.
    - Opcode 1/2 with N>=1 goes to DATA_REQ.
    - Any other opcode, or opcode 1/2 with N=0, increments err_count and returns to IDLE (header dropped).
  - DATA_REQ: wait while empty; on !empty, assert rcv_en_32 and go to DATA_WAIT.
  - DATA_WAIT: capture the word and write it to register (A+k) if A+k<NUM_REGS; otherwise consume and discard it. k++. If k==N, go to FINISH; else go to DATA_REQ.
  - FINISH: pulse cmd_done. Opcode 2 goes to START; otherwise go to IDLE.
  - START: pulse req_out for one cycle, go to WAIT_BUSY_HI.
  - WAIT_BUSY_HI: wait for busy_in=1 (core acknowledged), then go to WAIT_BUSY_LO. A timeout (BUSY_TIMEOUT cycles) increments err_count and goes to IDLE.
  - WAIT_BUSY_LO: wait for busy_in=0, then go to IDLE; same timeout rule.
- Register writes become visible on user_regs the cycle after DATA_WAIT.
- FIFO starvation mid-packet: stall indefinitely in DATA_REQ; no timeout, no error.
- Address wrap: A+k is computed in 9 bits; no wraparound into low registers.
- err_count saturates at 255.
- Throughput: 2 cycles per word minimum; header-to-first-write takes 5 cycles with a non-empty FIFO.

Decomposition:
- Shared package fifo_cmd_pkg:
  - opcode constants OP_WRITE=1, OP_WRITE_START=2, OP_START=3
  - header field bit positions
  - state encoding localparams
- Natural sub-module: cmd_reg_bank (NUM_REGS x 32 registers, synchronous write port with address/enable, sync clear).
- Handshake FSM and FIFO read logic stay in the top module.

Test Plan:
1. Load FIFO with 0x1000_0200, 0xDEADBEEF, 0x12345678 (WRITE, A=0, N=2) -> user_regs[0]=0xDEADBEEF, user_regs[1]=0x12345678, one cmd_done pulse, req_out never asserted.
2. Load 0x2000_0103, 0x5A5A5A5A (WRITE_START, A=3, N=1); model busy_in high 2 cycles after req_out for 10 cycles -> reg3=0x5A5A5A5A, cmd_done then a single req_out pulse, FSM back in IDLE after busy falls.
3. Load 0x1000_0303, 0x1, 0x2, 0x3 with NUM_REGS=4 -> reg3=0x1, the other two words consumed and discarded, FIFO empty, err_count=0.
4. Load 0x7000_0000 then 0x1000_0100, 0xAA -> err_count=1, reg0=0xAA (the valid packet still decodes).
5. Header 0x1000_0200, then empty FIFO for 50 cycles, then 0x11, 0x22 -> FSM stalls in DATA_REQ with rcv_en_32 low throughout, then reg0=0x11, reg1=0x22.
6. Assert rst_32 mid-packet after the first data word -> all regs 0, err_count=0. A new packet after reset decodes from a fresh header.
